oled_i2c_target: RTL and testbench

- I2C write-only target that models the SSD1306 receive side. It is the responder for the multi-byte OLED init/command stream of the form [address][control][cmd/arg]... on the same bus.
- It decodes START/STOP, matches the address, ACKs bytes, interprets control bytes (Co, D/C#) and emits each payload byte tagged as command or display data.
- Used for on-FPGA loopback verification of the OLED init path, and as a bus monitor in front of a display model.

---
 rtl/oled_i2c_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 38 +++
 rtl/oled_i2c_target.sv | 159 +++++++++++++++
 tb/tb_oled_i2c_target.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/oled_i2c_pkg.sv
// Shared types and constants for the SSD1306-style I2C write target.
package oled_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    CTRL,
    PAYLOAD,
    IGNORE
  } state_t;

  localparam int CTRL_CO_BIT = 7;
  localparam int CTRL_DC_BIT = 6;
  localparam logic [6:0] DEFAULT_I2C_ADDR7 = 7'h3C;

  // True for a write request (R/W# = 0) addressed to addr7.
  function automatic logic is_write_to(input logic [7:0] b, input logic [6:0] addr7);
    return (b[7:1] == addr7) && !b[0];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers on SCL/SDA plus an edge register; emits one-clk
// SCL edge and START/STOP pulses derived only from synchronised values.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] synchroniser stages, [2] previous value for edge detection
  logic [2:0] r_scl;
  logic [2:0] r_sda;
  logic       w_scl_high;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], scl_i};
      r_sda <= {r_sda[1:0], sda_i};
    end
  end

  // SDA edges only count as conditions while SCL has been stably high.
  assign w_scl_high = r_scl[1] & r_scl[2];
  assign sda        = r_sda[1];
  assign scl_rise   = r_scl[1] & ~r_scl[2];
  assign scl_fall   = ~r_scl[1] & r_scl[2];
  assign start_det  = w_scl_high & r_sda[2] & ~r_sda[1];
  assign stop_det   = w_scl_high & ~r_sda[2] & r_sda[1];

endmodule

// File: rtl/oled_i2c_target.sv
// Write-only I2C target modelling the SSD1306 receive side: address match,
// ACK generation, control-byte (Co, D/C#) decoding and tagged payload output.
module oled_i2c_target
  import oled_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR7 = DEFAULT_I2C_ADDR7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_is_data,
  output logic       xfer_active,
  output logic       stop_pulse
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  state_t     r_state, w_state_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic [7:0] r_shift, w_shift_next;
  logic       r_byte_done, w_byte_done_next;
  logic       r_in_ack, w_in_ack_next;
  logic       r_co, w_co_next;
  logic       r_dc, w_dc_next;
  logic       r_sda_oe, w_sda_oe_next;
  logic       r_byte_valid, w_byte_valid_next;
  logic [7:0] r_byte_out, w_byte_out_next;
  logic       r_byte_is_data, w_byte_is_data_next;
  logic       r_xfer_active, w_xfer_active_next;
  logic       r_stop_pulse, w_stop_pulse_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_bit_cnt      <= 3'd0;
      r_shift        <= 8'h00;
      r_byte_done    <= 1'b0;
      r_in_ack       <= 1'b0;
      r_co           <= 1'b0;
      r_dc           <= 1'b0;
      r_sda_oe       <= 1'b0;
      r_byte_valid   <= 1'b0;
      r_byte_out     <= 8'h00;
      r_byte_is_data <= 1'b0;
      r_xfer_active  <= 1'b0;
      r_stop_pulse   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_bit_cnt      <= w_bit_cnt_next;
      r_shift        <= w_shift_next;
      r_byte_done    <= w_byte_done_next;
      r_in_ack       <= w_in_ack_next;
      r_co           <= w_co_next;
      r_dc           <= w_dc_next;
      r_sda_oe       <= w_sda_oe_next;
      r_byte_valid   <= w_byte_valid_next;
      r_byte_out     <= w_byte_out_next;
      r_byte_is_data <= w_byte_is_data_next;
      r_xfer_active  <= w_xfer_active_next;
      r_stop_pulse   <= w_stop_pulse_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_bit_cnt_next      = r_bit_cnt;
    w_shift_next        = r_shift;
    w_byte_done_next    = r_byte_done;
    w_in_ack_next       = r_in_ack;
    w_co_next           = r_co;
    w_dc_next           = r_dc;
    w_sda_oe_next       = r_sda_oe;
    w_byte_valid_next   = 1'b0;
    w_byte_out_next     = r_byte_out;
    w_byte_is_data_next = r_byte_is_data;
    w_xfer_active_next  = r_xfer_active;
    w_stop_pulse_next   = 1'b0;

    if (w_stop || w_start) begin
      // Bus conditions abort any partial byte and release SDA.
      w_state_next       = w_stop ? IDLE : ADDR;
      w_stop_pulse_next  = w_stop;
      w_bit_cnt_next     = 3'd0;
      w_byte_done_next   = 1'b0;
      w_in_ack_next      = 1'b0;
      w_sda_oe_next      = 1'b0;
      w_xfer_active_next = 1'b0;
    end else begin
      case (r_state)
        ADDR, CTRL, PAYLOAD: begin
          if (w_scl_rise && !r_byte_done && !r_in_ack) begin
            w_shift_next   = {r_shift[6:0], w_sda};
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_byte_done_next = 1'b1;
          end else if (w_scl_fall && r_in_ack) begin
            // End of the ACK clock: hand SDA back and pick the next byte type.
            w_sda_oe_next = 1'b0;
            w_in_ack_next = 1'b0;
            if (r_state == CTRL) w_state_next = PAYLOAD;
            else                 w_state_next = r_co ? CTRL : PAYLOAD;
          end else if (w_scl_fall && r_byte_done) begin
            w_byte_done_next = 1'b0;
            if (r_state == ADDR) begin
              if (is_write_to(r_shift, I2C_ADDR7)) begin
                w_state_next       = ADDR_ACK;
                w_sda_oe_next      = 1'b1;
                w_xfer_active_next = 1'b1;
              end else begin
                w_state_next = IGNORE;
              end
            end else begin
              w_sda_oe_next = 1'b1;
              w_in_ack_next = 1'b1;
              if (r_state == CTRL) begin
                w_co_next = r_shift[CTRL_CO_BIT];
                w_dc_next = r_shift[CTRL_DC_BIT];
              end else begin
                w_byte_valid_next   = 1'b1;
                w_byte_out_next     = r_shift;
                w_byte_is_data_next = r_dc;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_next = 1'b0;
            w_state_next  = CTRL;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe       = r_sda_oe;
  assign byte_valid   = r_byte_valid;
  assign byte_out     = r_byte_out;
  assign byte_is_data = r_byte_is_data;
  assign xfer_active  = r_xfer_active;
  assign stop_pulse   = r_stop_pulse;

endmodule

// File: tb/tb_oled_i2c_target.sv
// Bus-level bench: an I2C master drives byte frames; a frame-level model
// predicts ACKs and the tagged payload stream.
module tb_oled_i2c_target;

  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, byte_valid, byte_is_data, xfer_active, stop_pulse;
  logic [7:0] byte_out;

  assign sda_bus = sda_m & ~sda_oe;

  oled_i2c_target dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_i        (scl_m),
    .sda_i        (sda_bus),
    .sda_oe       (sda_oe),
    .byte_valid   (byte_valid),
    .byte_out     (byte_out),
    .byte_is_data (byte_is_data),
    .xfer_active  (xfer_active),
    .stop_pulse   (stop_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor
  int         cyc = 0;
  int         fall_cyc = 0;
  int         stop_cnt = 0;
  int         oe_seen = 0;
  logic [8:0] got_q[$];

  always @(posedge clk) cyc++;
  always @(negedge scl_m) fall_cyc = cyc;

  always @(negedge clk) begin
    if (byte_valid || stop_pulse) check_val("excl", 32'(byte_valid & stop_pulse), 0);
    if (byte_valid) begin
      got_q.push_back({byte_is_data, byte_out});
      check_val("latency", 32'((cyc - fall_cyc) <= 4), 1);
    end
    if (stop_pulse) stop_cnt++;
    if (sda_oe) oe_seen = 1;
  end

  // Master bus primitives
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
    end
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    ack = ~sda_bus;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  // Frame-level reference model
  logic [7:0] tx_q[$];
  logic [8:0] exp_q[$];
  logic       cur_matched;

  task automatic model_txn();
    logic expect_ctrl, co, dc;
    cur_matched = (tx_q[0][7:1] == 7'h3C) && !tx_q[0][0];
    expect_ctrl = 1'b1;
    co = 1'b0;
    dc = 1'b0;
    if (cur_matched) begin
      for (int i = 1; i < tx_q.size(); i++) begin
        if (expect_ctrl) begin
          co = tx_q[i][7];
          dc = tx_q[i][6];
          expect_ctrl = 1'b0;
        end else begin
          exp_q.push_back({dc, tx_q[i]});
          expect_ctrl = co;
        end
      end
    end
  endtask

  task automatic send_frame();
    logic ack;
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], ack);
      check_val("ack", 32'(ack), 32'(cur_matched));
      check_val("xfer", 32'(xfer_active), 32'(cur_matched));
    end
  endtask

  task automatic end_checks(input int stops0);
    check_val("xfer_end", 32'(xfer_active), 0);
    check_val("stop_cnt", stop_cnt - stops0, 1);
    check_val("n_bytes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val("byte", 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_txn();
    int stops0;
    model_txn();
    stops0 = stop_cnt;
    oe_seen = 0;
    i2c_start();
    send_frame();
    i2c_stop();
    if (!cur_matched) check_val("oe_seen", oe_seen, 0);
    end_checks(stops0);
  endtask

  initial begin
    int         stops0;
    int         n;
    logic       ack;
    logic [7:0] a;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    wait_clk(3);
    check_val("rst_oe",    32'(sda_oe), 0);
    check_val("rst_bv",    32'(byte_valid), 0);
    check_val("rst_bout",  32'(byte_out), 0);
    check_val("rst_isd",   32'(byte_is_data), 0);
    check_val("rst_xfer",  32'(xfer_active), 0);
    check_val("rst_stop",  32'(stop_pulse), 0);
    rst_n = 1'b1;
    wait_clk(4);

    tx_q = '{8'h78, 8'h00, 8'hAE, 8'hD5, 8'h80};
    run_txn();
    tx_q = '{8'h78, 8'h80, 8'hAF, 8'h40, 8'h12};
    run_txn();
    tx_q = '{8'h7A, 8'h00, 8'hAE};
    run_txn();
    tx_q = '{8'h79, 8'h00, 8'h55};
    run_txn();

    // Partial byte abandoned by a repeated START
    stops0 = stop_cnt;
    tx_q = '{8'h78, 8'h40, 8'hFF};
    model_txn();
    i2c_start();
    send_frame();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    tx_q = '{8'h78, 8'h00, 8'hA5};
    model_txn();
    i2c_start();
    check_val("xfer_rs", 32'(xfer_active), 0);
    send_frame();
    i2c_stop();
    end_checks(stops0);

    // Reset while the target holds the address ACK
    stops0 = stop_cnt;
    a = 8'h78;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    wait_clk(5);
    check_val("oe_ack", 32'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    check_val("oe_rst", 32'(sda_oe), 0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
    write_byte(8'h00, ack);
    check_val("ack_after_rst", 32'(ack), 0);
    write_byte(8'hAE, ack);
    check_val("ack_after_rst", 32'(ack), 0);
    i2c_stop();
    end_checks(stops0);

    // Randomized frames
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = 8'h78;
        3:       a = 8'h79;
        4:       a = 8'h7A;
        default: a = 8'($urandom_range(0, 255));
      endcase
      tx_q.delete();
      tx_q.push_back(a);
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      run_txn();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
